halflife_meter: RTL and testbench

//  Reader-side companion to the half-life timer. Samples the timer's 4-bit count output,

---
 rtl/halflife_pkg.sv | 17 +
 rtl/halflife_sat_counter.sv | 48 ++++
 rtl/halflife_meter.sv | 180 ++++++++++++++++++
 tb/tb_halflife_meter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/halflife_pkg.sv
// Shared constants for the half-life meter: state encoding, default widths
// and the default saturation limit of the period counter.
package halflife_pkg;

  localparam int VAL_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_REPORT  = 2'd2;

  // Saturation value of a counter of the default width
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

endpackage

// File: rtl/halflife_sat_counter.sv
// Saturating cycle counter. count_inc is the value the counter takes on the
// next enabled edge; at_max flags that this next value is the saturation
// limit, so the caller can react in the same cycle the limit is reached.
module halflife_sat_counter import halflife_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_inc,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] LIMIT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};

  logic [CNT_W-1:0] count_r;

  // Next value of the counter, held at the limit once reached
  always_comb begin
    count_inc = count_r;
    if (count_r == LIMIT) begin
      count_inc = LIMIT;
    end else begin
      count_inc = count_r + ONE;
    end
    at_max = (count_inc == LIMIT);
  end

  // Counter register: clear has priority over enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO;
    end else if (clear) begin
      count_r <= ZERO;
    end else if (enable) begin
      count_r <= count_inc;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/halflife_meter.sv
// Half-life meter: captures a reference from the timer's count on start and
// measures how many cycles pass until the count falls to half the reference.
// All outputs come straight from registers.
module halflife_meter import halflife_pkg::*; #(
  parameter int VAL_W = VAL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             invalid,
  output logic [VAL_W-1:0] ref_val,
  output logic [CNT_W-1:0] period
);

  localparam logic [VAL_W-1:0] VAL_ZERO = {VAL_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [VAL_W-1:0] thresh_r;
  logic [VAL_W-1:0] ref_val_r;
  logic [CNT_W-1:0] period_r;
  logic             busy_r;
  logic             done_r;
  logic             timeout_r;
  logic             invalid_r;

  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             timeout_nxt_s;
  logic             invalid_nxt_s;

  logic             accept_s;
  logic             count_en_s;
  logic             hit_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] count_inc_s;
  logic             at_max_s;

  // Qualifiers shared by the FSM and the datapath
  always_comb begin
    accept_s   = (state_r == ST_IDLE) && start;
    count_en_s = (state_r == ST_MEASURE) && !abort;
    hit_s      = (value <= thresh_r);
  end

  halflife_sat_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_s),
    .enable    (count_en_s),
    .count     (count_s),
    .count_inc (count_inc_s),
    .at_max    (at_max_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: abort beats the threshold, the threshold beats saturation
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (value != VAL_ZERO)) begin
          state_nxt_s = ST_MEASURE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (hit_s || at_max_s) begin
          state_nxt_s = ST_REPORT;
        end else begin
          state_nxt_s = ST_MEASURE;
        end
      end
      ST_REPORT: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, computed one cycle ahead so they can be registered
  always_comb begin
    done_nxt_s    = 1'b0;
    timeout_nxt_s = 1'b0;
    invalid_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (value == VAL_ZERO)) begin
          invalid_nxt_s = 1'b1;
        end else begin
          invalid_nxt_s = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          done_nxt_s    = 1'b0;
          timeout_nxt_s = 1'b0;
        end else if (hit_s) begin
          done_nxt_s    = 1'b1;
        end else if (at_max_s) begin
          timeout_nxt_s = 1'b1;
        end else begin
          done_nxt_s    = 1'b0;
          timeout_nxt_s = 1'b0;
        end
      end
      default: begin
        done_nxt_s    = 1'b0;
        timeout_nxt_s = 1'b0;
        invalid_nxt_s = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_MEASURE);
  end

  // Status/pulse output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      invalid_r <= 1'b0;
    end else begin
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      timeout_r <= timeout_nxt_s;
      invalid_r <= invalid_nxt_s;
    end
  end

  // Reference, threshold and measured period; all held until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_val_r <= VAL_ZERO;
      thresh_r  <= VAL_ZERO;
      period_r  <= CNT_ZERO;
    end else if (accept_s) begin
      ref_val_r <= value;
      thresh_r  <= value >> 1;
      period_r  <= CNT_ZERO;
    end else if (done_nxt_s) begin
      period_r  <= count_inc_s;
    end else if (timeout_nxt_s) begin
      period_r  <= CNT_ONES;
    end else begin
      period_r  <= period_r;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign timeout = timeout_r;
  assign invalid = invalid_r;
  assign ref_val = ref_val_r;
  assign period  = period_r;

endmodule

// File: tb/tb_halflife_meter.sv
// Scoreboard bench for halflife_meter: one instance with the default 16-bit
// counter and one with a 4-bit counter for the saturation cases.
module tb_halflife_meter;

  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_TO   = 2'd2;
  localparam logic [1:0] K_INV  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  refv;
    logic [15:0] per;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [3:0]  value_a = 4'd0;
  logic        busy_a, done_a, timeout_a, invalid_a;
  logic [3:0]  ref_a;
  logic [15:0] period_a;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [3:0]  value_b = 4'd0;
  logic        busy_b, done_b, timeout_b, invalid_b;
  logic [3:0]  ref_b;
  logic [3:0]  period_b;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];
  exp_t mon_e_a, mon_e_b;

  int n_checks = 0;
  int n_pass   = 0;

  halflife_meter #(.VAL_W(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .value(value_a),
    .busy(busy_a), .done(done_a), .timeout(timeout_a), .invalid(invalid_a),
    .ref_val(ref_a), .period(period_a)
  );

  halflife_meter #(.VAL_W(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .value(value_b),
    .busy(busy_b), .done(done_b), .timeout(timeout_b), .invalid(invalid_b),
    .ref_val(ref_b), .period(period_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the 16-bit instance
  always @(negedge clk) begin
    if (!rst && (done_a || timeout_a || invalid_a)) begin
      check_val("one_pulse_a", 32'(done_a) + 32'(timeout_a) + 32'(invalid_a), 32'd1);
      check_val("sb_has_exp_a", 32'(exp_q_a.size() != 0), 32'd1);
      if (exp_q_a.size() != 0) begin
        mon_e_a = exp_q_a.pop_front();
        check_val("kind_a", done_a ? 32'(K_DONE) : (timeout_a ? 32'(K_TO) : 32'(K_INV)), 32'(mon_e_a.kind));
        check_val("ref_a", 32'(ref_a), 32'(mon_e_a.refv));
        check_val("period_a", 32'(period_a), 32'(mon_e_a.per));
      end
    end
  end

  // Scoreboard monitor for the 4-bit instance
  always @(negedge clk) begin
    if (!rst && (done_b || timeout_b || invalid_b)) begin
      check_val("one_pulse_b", 32'(done_b) + 32'(timeout_b) + 32'(invalid_b), 32'd1);
      check_val("sb_has_exp_b", 32'(exp_q_b.size() != 0), 32'd1);
      if (exp_q_b.size() != 0) begin
        mon_e_b = exp_q_b.pop_front();
        check_val("kind_b", done_b ? 32'(K_DONE) : (timeout_b ? 32'(K_TO) : 32'(K_INV)), 32'(mon_e_b.kind));
        check_val("ref_b", 32'(ref_b), 32'(mon_e_b.refv));
        check_val("period_b", 32'(period_b), 32'(mon_e_b.per));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check_val("rst_busy_a", 32'(busy_a), 32'd0);
    check_val("rst_pulses_a", 32'({done_a, timeout_a, invalid_a}), 32'd0);
    check_val("rst_ref_a", 32'(ref_a), 32'd0);
    check_val("rst_period_a", 32'(period_a), 32'd0);
    check_val("rst_busy_b", 32'(busy_b), 32'd0);
    check_val("rst_period_b", 32'(period_b), 32'd0);
    rst = 1'b0;
    tick();

    // 1: ref 8, value stays 8 for 9 measure cycles then drops to 4 -> period 10
    value_a = 4'd8; start_a = 1'b1;
    exp_q_a.push_back('{kind: K_DONE, refv: 4'd8, per: 16'd10});
    tick();
    start_a = 1'b0;
    check_val("t1_busy_up", 32'(busy_a), 32'd1);
    repeat (9) tick();
    value_a = 4'd4;
    tick();
    check_val("t1_done", 32'(done_a), 32'd1);
    tick();
    check_val("t1_busy_down", 32'(busy_a), 32'd0);
    check_val("t1_done_1cyc", 32'(done_a), 32'd0);
    check_val("t1_period_held", 32'(period_a), 32'd10);

    // 2: start with value 0 -> invalid next cycle, never busy
    value_a = 4'd0; start_a = 1'b1;
    exp_q_a.push_back('{kind: K_INV, refv: 4'd0, per: 16'd0});
    tick();
    start_a = 1'b0;
    check_val("t2_invalid", 32'(invalid_a), 32'd1);
    check_val("t2_busy", 32'(busy_a), 32'd0);
    tick();
    check_val("t2_busy_after", 32'(busy_a), 32'd0);
    check_val("t2_period", 32'(period_a), 32'd0);

    // 4: ref 9, abort on the 5th measure cycle -> idle, no pulse
    value_a = 4'd9; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check_val("t4_busy_abort", 32'(busy_a), 32'd0);
    check_val("t4_period_abort", 32'(period_a), 32'd0);
    check_val("t4_ref", 32'(ref_a), 32'd9);
    // new start right away: ref 2, value 1 on the first cycle -> period 1
    value_a = 4'd2; start_a = 1'b1;
    exp_q_a.push_back('{kind: K_DONE, refv: 4'd2, per: 16'd1});
    tick();
    start_a = 1'b0; value_a = 4'd1;
    check_val("t4_restart_busy", 32'(busy_a), 32'd1);
    tick();
    tick();

    // abort together with threshold: abort wins, no pulse expected
    value_a = 4'd8; start_a = 1'b1;
    tick();
    start_a = 1'b0; value_a = 4'd2; abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check_val("abort_vs_hit_busy", 32'(busy_a), 32'd0);
    tick();

    // 5: start held high through MEASURE and REPORT -> ignored; period 3
    value_a = 4'd4; start_a = 1'b1;
    exp_q_a.push_back('{kind: K_DONE, refv: 4'd4, per: 16'd3});
    tick();
    tick();
    tick();
    value_a = 4'd2;
    tick();
    check_val("t5_done", 32'(done_a), 32'd1);
    tick();
    start_a = 1'b0;
    check_val("t5_report_start_ignored", 32'(busy_a), 32'd0);
    check_val("t5_no_invalid", 32'(invalid_a), 32'd0);
    tick();

    // 5b: reset mid-measure clears every output at once
    value_a = 4'd8; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_val("t5_rst_busy", 32'(busy_a), 32'd0);
    check_val("t5_rst_ref", 32'(ref_a), 32'd0);
    tick();
    check_val("t5_rst_all", 32'({busy_a, done_a, timeout_a, invalid_a, ref_a, period_a}), 32'd0);
    rst = 1'b0;
    tick();

    // 6: ref 1 (thresh 0), value 0 next cycle -> period 1, done right after
    value_a = 4'd1; start_a = 1'b1;
    exp_q_a.push_back('{kind: K_DONE, refv: 4'd1, per: 16'd1});
    tick();
    start_a = 1'b0; value_a = 4'd0;
    tick();
    check_val("t6_done_latency", 32'(done_a), 32'd1);
    check_val("t6_period", 32'(period_a), 32'd1);
    tick();

    // 3: 4-bit counter, value held at 6 -> timeout after 15 measure cycles
    value_b = 4'd6; start_b = 1'b1;
    exp_q_b.push_back('{kind: K_TO, refv: 4'd6, per: 16'd15});
    tick();
    start_b = 1'b0;
    repeat (14) tick();
    check_val("t3_no_early_to", 32'(timeout_b), 32'd0);
    check_val("t3_busy", 32'(busy_b), 32'd1);
    tick();
    check_val("t3_timeout", 32'(timeout_b), 32'd1);
    check_val("t3_no_done", 32'(done_b), 32'd0);
    tick();
    check_val("t3_busy_down", 32'(busy_b), 32'd0);

    // 6b: threshold met in the saturating cycle -> done, not timeout
    value_b = 4'd6; start_b = 1'b1;
    exp_q_b.push_back('{kind: K_DONE, refv: 4'd6, per: 16'd15});
    tick();
    start_b = 1'b0;
    repeat (14) tick();
    value_b = 4'd3;
    tick();
    check_val("t6b_done", 32'(done_b), 32'd1);
    check_val("t6b_no_timeout", 32'(timeout_b), 32'd0);
    tick();
    tick();

    check_val("sb_drained_a", 32'(exp_q_a.size()), 32'd0);
    check_val("sb_drained_b", 32'(exp_q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
